// File: rtl/ecc_result_fifo_if.sv
// ecc_result_fifo_if: result capture and consumer stream signals of the ECC result FIFO.
// The slave modport is the FIFO. The master modport is the producer/consumer side.
interface ecc_result_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ecc_data;
  logic [1:0]            ecc_nof;
  logic                  ecc_done;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_nof;

  modport slave (
    input  ecc_data, ecc_nof, ecc_done, out_ready,
    output out_valid, out_data, out_nof
  );

  modport master (
    output ecc_data, ecc_nof, ecc_done, out_ready,
    input  out_valid, out_data, out_nof
  );
endinterface

// File: rtl/ecc_result_fifo.sv
// ecc_result_fifo: captures each ECC result (data + error class) on the rising edge of
// operation_done and buffers it in a DEPTH-entry circular FIFO. The FIFO drains on a
// valid/ready stream. A sticky overflow flag records dropped results.
// Optional macro ECC_RESULT_FIFO_STATS_EN builds the saturating per-class result counters.
// When the macro is undefined, cnt_* read as zero and clr_stats clears only overflow.
// The interface DATA_WIDTH must match this module's DATA_WIDTH.
module ecc_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ecc_result_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clr_stats,
  output logic [CNT_WIDTH-1:0]   cnt_ok,
  output logic [CNT_WIDTH-1:0]   cnt_one,
  output logic [CNT_WIDTH-1:0]   cnt_two
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic                  done_q_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  overflow_r;
  logic [DATA_WIDTH-1:0] mem_data_r [DEPTH];
  logic [1:0]            mem_nof_r  [DEPTH];

  logic push_s;
  logic pop_s;
  logic full_s;
  logic valid_s;
  logic wr_en_s;
  logic ovf_set_s;

  // Handshake decode: edge-detected capture, consumer pop, and write/drop decision.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    full_s    = 1'b0;
    valid_s   = 1'b0;
    wr_en_s   = 1'b0;
    ovf_set_s = 1'b0;
    valid_s   = (count_r != {CW{1'b0}});
    full_s    = (count_r == CW'(DEPTH));
    push_s    = bus.ecc_done & ~done_q_r;
    pop_s     = valid_s & bus.out_ready;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    if (push_s && (!full_s || pop_s)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    ovf_set_s = push_s & full_s & ~pop_s;
  end

  // Control state: done edge detector, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q_r   <= 1'b0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      done_q_r <= bus.ecc_done;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      // Clearing wins over a same-cycle drop so software always sees a clean flag.
      if (clr_stats) begin
        overflow_r <= 1'b0;
      end else if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage: contents need no reset because out_valid qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_data_r[wr_ptr_r] <= bus.ecc_data;
      mem_nof_r[wr_ptr_r]  <= bus.ecc_nof;
    end
  end

  assign bus.out_valid = valid_s;
  assign bus.out_data  = valid_s ? mem_data_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
  assign bus.out_nof   = valid_s ? mem_nof_r[rd_ptr_r]  : 2'b00;
  assign fifo_count    = count_r;
  assign overflow      = overflow_r;

`ifdef ECC_RESULT_FIFO_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_ok_r;
  logic [CNT_WIDTH-1:0] cnt_one_r;
  logic [CNT_WIDTH-1:0] cnt_two_r;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Per-class statistics: every captured result counts, even one dropped on overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_ok_r  <= {CNT_WIDTH{1'b0}};
      cnt_one_r <= {CNT_WIDTH{1'b0}};
      cnt_two_r <= {CNT_WIDTH{1'b0}};
    end else if (clr_stats) begin
      cnt_ok_r  <= {CNT_WIDTH{1'b0}};
      cnt_one_r <= {CNT_WIDTH{1'b0}};
      cnt_two_r <= {CNT_WIDTH{1'b0}};
    end else if (push_s) begin
      case (bus.ecc_nof)
        2'b00:   cnt_ok_r  <= sat_inc(cnt_ok_r);
        2'b01:   cnt_one_r <= sat_inc(cnt_one_r);
        default: cnt_two_r <= sat_inc(cnt_two_r);
      endcase
    end
  end

  assign cnt_ok  = cnt_ok_r;
  assign cnt_one = cnt_one_r;
  assign cnt_two = cnt_two_r;
`else
  assign cnt_ok  = {CNT_WIDTH{1'b0}};
  assign cnt_one = {CNT_WIDTH{1'b0}};
  assign cnt_two = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_ecc_result_fifo.sv
// tb_ecc_result_fifo: self-checking bench for ecc_result_fifo (DEPTH=4, CNT_WIDTH=4).
// A queue-based reference model tracks contents, overflow and per-class statistics.
// Counter expectations follow ECC_RESULT_FIFO_STATS_EN.
module tb_ecc_result_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
`ifdef ECC_RESULT_FIFO_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    n;
  } ent_t;

  logic            clk;
  logic            rst;
  logic            clr_stats;
  logic [2:0]      fifo_count;
  logic            overflow;
  logic [CNTW-1:0] cnt_ok;
  logic [CNTW-1:0] cnt_one;
  logic [CNTW-1:0] cnt_two;

  ecc_result_fifo_if #(.DATA_WIDTH(DW)) bus ();

  ecc_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_stats  (clr_stats),
    .cnt_ok     (cnt_ok),
    .cnt_one    (cnt_one),
    .cnt_two    (cnt_two)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t m_q[$];
  bit   m_done_q;
  bit   m_ovf;
  int   m_ok, m_one, m_two;

  function automatic logic [CNTW-1:0] exp_cnt(input int v);
    return STATS_EN ? CNTW'(v) : {CNTW{1'b0}};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_done_q = 1'b0;
    m_ovf    = 1'b0;
    m_ok = 0; m_one = 0; m_two = 0;
  endtask

  // Apply one rising edge to the model using the current inputs, then advance the DUT.
  task automatic cycle();
    bit   push, pop, full;
    ent_t e;
    push = bus.ecc_done && !m_done_q;
    pop  = (m_q.size() != 0) && bus.out_ready;
    full = (m_q.size() == DEPTH);
    e.d = bus.ecc_data;
    e.n = bus.ecc_nof;
    if (pop) m_q.delete(0);
    if (push && (!full || pop)) m_q.push_back(e);
    if (clr_stats) m_ovf = 1'b0;
    else if (push && full && !pop) m_ovf = 1'b1;
    if (clr_stats) begin
      m_ok = 0; m_one = 0; m_two = 0;
    end else if (push) begin
      if (e.n == 2'd0) m_ok = (m_ok < 15) ? m_ok + 1 : 15;
      else if (e.n == 2'd1) m_one = (m_one < 15) ? m_one + 1 : 15;
      else m_two = (m_two < 15) ? m_two + 1 : 15;
    end
    m_done_q = bus.ecc_done;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] d, input logic [1:0] n);
    bus.ecc_data = d;
    bus.ecc_nof  = n;
    bus.ecc_done = 1'b1;
    cycle();
    bus.ecc_done = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr_stats = 1'b0;
    bus.ecc_done = 1'b0;
    bus.ecc_data = '0;
    bus.ecc_nof = 2'd0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 ||
        bus.out_data !== 32'd0 || bus.out_nof !== 2'd0 ||
        cnt_ok !== 4'd0 || cnt_one !== 4'd0 || cnt_two !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b count=%0d ovf=%b data=%h nof=%0d cnt=%0d/%0d/%0d, required all 0",
               bus.out_valid, fifo_count, overflow, bus.out_data, bus.out_nof, cnt_ok, cnt_one, cnt_two);
    end
  endtask

  task automatic test_capture();
    pulse(32'h0000_00A5, 2'd0);
    pulse(32'h0000_1234, 2'd1);
    pulse(32'hDEAD_BEEF, 2'd2);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++; $display("FAIL capture_count: got %0d required 3", fifo_count);
    end
    checks++;
    if (bus.out_data !== 32'h0000_00A5 || bus.out_nof !== 2'd0) begin
      errors++; $display("FAIL capture_head: got %h/%0d required 000000a5/0", bus.out_data, bus.out_nof);
    end
    checks++;
    if (cnt_ok !== exp_cnt(1) || cnt_one !== exp_cnt(1) || cnt_two !== exp_cnt(1)) begin
      errors++; $display("FAIL capture_stats: got %0d/%0d/%0d required %0d each",
                         cnt_ok, cnt_one, cnt_two, exp_cnt(1));
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp_d [3];
    logic [1:0]    exp_n [3];
    exp_d[0] = 32'h0000_00A5; exp_d[1] = 32'h0000_1234; exp_d[2] = 32'hDEAD_BEEF;
    exp_n[0] = 2'd0; exp_n[1] = 2'd1; exp_n[2] = 2'd2;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i] || bus.out_nof !== exp_n[i]) begin
        errors++; $display("FAIL drain_%0d: got v=%b %h/%0d required v=1 %h/%0d",
                           i, bus.out_valid, bus.out_data, bus.out_nof, exp_d[i], exp_n[i]);
      end
      cycle();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL drain_empty: got v=%b count=%0d required 0/0", bus.out_valid, fifo_count);
    end
  endtask

  task automatic test_overflow();
    clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
    for (int i = 1; i <= 5; i++) pulse(DW'(i), 2'd0);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_set: got count=%0d ovf=%b required 4/1", fifo_count, overflow);
    end
    checks++;
    if (cnt_ok !== exp_cnt(5)) begin
      errors++; $display("FAIL overflow_stats: got %0d required %0d", cnt_ok, exp_cnt(5));
    end
    clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
    checks++;
    if (overflow !== 1'b0 || cnt_ok !== 4'd0 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL clr_stats: got ovf=%b cnt_ok=%0d count=%0d required 0/0/4",
                         overflow, cnt_ok, fifo_count);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp_d [4];
    exp_d[0] = 32'd2; exp_d[1] = 32'd3; exp_d[2] = 32'd4; exp_d[3] = 32'd6;
    bus.ecc_data = 32'd6; bus.ecc_nof = 2'd1; bus.ecc_done = 1'b1; bus.out_ready = 1'b1;
    checks++;
    if (bus.out_data !== 32'd1) begin
      errors++; $display("FAIL full_head: got %h required 1", bus.out_data);
    end
    cycle();
    bus.ecc_done = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_push_pop: got count=%0d ovf=%b required 4/0", fifo_count, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_data !== exp_d[i]) begin
        errors++; $display("FAIL full_order_%0d: got %h required %h", i, bus.out_data, exp_d[i]);
      end
      cycle();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++; $display("FAIL full_drained: got %0d required 0", fifo_count);
    end
  endtask

  task automatic test_held_done_and_reset();
    bus.ecc_data = 32'h5555_AAAA; bus.ecc_nof = 2'd3; bus.ecc_done = 1'b1;
    repeat (5) cycle();
    bus.ecc_done = 1'b0;
    cycle();
    checks++;
    if (fifo_count !== 3'd1 || bus.out_nof !== 2'd3 || bus.out_data !== 32'h5555_AAAA) begin
      errors++; $display("FAIL held_done: got count=%0d %h/%0d required 1 5555aaaa/3",
                         fifo_count, bus.out_data, bus.out_nof);
    end
    checks++;
    if (cnt_two !== exp_cnt(1)) begin
      errors++; $display("FAIL held_done_stats: got %0d required %0d", cnt_two, exp_cnt(1));
    end
    pulse(32'h0BAD_F00D, 2'd1);
    bus.ecc_done = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 ||
        bus.out_data !== 32'd0 || bus.out_nof !== 2'd0 ||
        cnt_ok !== 4'd0 || cnt_one !== 4'd0 || cnt_two !== 4'd0) begin
      errors++; $display("FAIL async_reset: valid=%b count=%0d ovf=%b data=%h nof=%0d cnt=%0d/%0d/%0d required all 0",
                         bus.out_valid, fifo_count, overflow, bus.out_data, bus.out_nof, cnt_ok, cnt_one, cnt_two);
    end
    bus.ecc_done = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) pulse($urandom, 2'd1);
    checks++;
    if (cnt_one !== exp_cnt(15) || overflow !== 1'b0) begin
      errors++; $display("FAIL saturation: got cnt_one=%0d ovf=%b required %0d/0", cnt_one, overflow, exp_cnt(15));
    end
    bus.out_ready = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.ecc_done  = ($urandom_range(0, 1) == 1);
      bus.ecc_data  = $urandom;
      bus.ecc_nof   = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 9) < 4);
      clr_stats     = ($urandom_range(0, 49) == 0);
      cycle();
      checks++;
      if (bus.out_valid !== (m_q.size() != 0) || fifo_count !== 3'(m_q.size()) || overflow !== m_ovf) begin
        errors++; $display("FAIL rand_ctrl_%0d: got v=%b count=%0d ovf=%b required v=%b count=%0d ovf=%b",
                           i, bus.out_valid, fifo_count, overflow, (m_q.size() != 0), m_q.size(), m_ovf);
      end
      checks++;
      if (cnt_ok !== exp_cnt(m_ok) || cnt_one !== exp_cnt(m_one) || cnt_two !== exp_cnt(m_two)) begin
        errors++; $display("FAIL rand_stats_%0d: got %0d/%0d/%0d required %0d/%0d/%0d", i,
                           cnt_ok, cnt_one, cnt_two, exp_cnt(m_ok), exp_cnt(m_one), exp_cnt(m_two));
      end
      if (m_q.size() != 0) begin
        checks++;
        if (bus.out_data !== m_q[0].d || bus.out_nof !== m_q[0].n) begin
          errors++; $display("FAIL rand_head_%0d: got %h/%0d required %h/%0d",
                             i, bus.out_data, bus.out_nof, m_q[0].d, m_q[0].n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_drain();
    test_overflow();
    test_full_push_pop();
    test_held_done_and_reset();
    test_saturation();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
